// File: rtl/oq_dst_dispatch_pkg.sv
// Shared constants and state encoding for the output-queue destination dispatcher.
package oq_dst_dispatch_pkg;

  localparam logic [7:0] IOQ_STAGE_NUM    = 8'hFF;
  localparam int         IOQ_DST_PORT_POS = 48;
  localparam int         IOQ_SRC_PORT_POS = 16;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    HDRS    = 4'b0010,
    PAYLOAD = 4'b0100,
    DROP    = 4'b1000
  } state_t;

endpackage

// File: rtl/oq_dst_dispatch_small_fifo.sv
// Small synchronous FIFO with a combinational head word and a nearly-full flag.
module oq_dst_dispatch_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      full;
  logic                      push;
  logic                      pop;

  assign full        = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 2));
  assign empty       = (depth == '0);
  assign push        = wr_en && !full;
  assign pop         = rd_en && !empty;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/oq_dst_dispatch.sv
// Reads the IO-queue header bitmap of each packet and replicates the packet
// onto the selected output queues; empty-bitmap packets are dropped.
module oq_dst_dispatch #(
  parameter int                         DATA_WIDTH        = 64,
  parameter int                         CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int                         NUM_OUTPUT_QUEUES = 8,
  parameter logic [CTRL_WIDTH-1:0]      IOQ_STAGE_NUM     = CTRL_WIDTH'(oq_dst_dispatch_pkg::IOQ_STAGE_NUM),
  parameter int                         IOQ_DST_PORT_POS  = oq_dst_dispatch_pkg::IOQ_DST_PORT_POS,
  parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_PORTS   = NUM_OUTPUT_QUEUES'(8'b01010101),
  parameter int                         FIFO_DEPTH_BITS   = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy,
  output logic [31:0]                  pkt_count,
  output logic [31:0]                  drop_count,
  output logic [31:0]                  hdr_err_count
);
  import oq_dst_dispatch_pkg::*;

  if (NUM_OUTPUT_QUEUES > DATA_WIDTH - IOQ_DST_PORT_POS) begin : g_bad_cfg
    $error("oq_dst_dispatch: destination bitmap does not fit in the header word");
  end

  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout;
  logic                             fifo_nearly_full;
  logic                             fifo_empty;
  logic [DATA_WIDTH-1:0]            head_data;
  logic [CTRL_WIDTH-1:0]            head_ctrl;
  logic [NUM_OUTPUT_QUEUES-1:0]     hdr_bitmap;

  state_t                           state, state_nxt;
  logic [NUM_OUTPUT_QUEUES-1:0]     bitmap, bitmap_nxt;
  logic                             drop_pl, drop_pl_nxt;
  logic                             pop;
  logic                             send;
  logic                             pkt_inc, drop_inc, err_inc;

  oq_dst_dispatch_small_fifo #(
    .WIDTH          (DATA_WIDTH + CTRL_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (pop),
    .dout        (fifo_dout),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign {head_ctrl, head_data} = fifo_dout;
  assign hdr_bitmap = head_data[IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
  assign in_rdy     = !fifo_nearly_full;
  assign out_data   = head_data;
  assign out_ctrl   = head_ctrl;
  // All selected queues must be ready together so copies never diverge.
  assign send       = !fifo_empty && ((out_rdy & bitmap) == bitmap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bitmap  <= '0;
      drop_pl <= 1'b0;
    end else begin
      state   <= state_nxt;
      bitmap  <= bitmap_nxt;
      drop_pl <= drop_pl_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bitmap_nxt  = bitmap;
    drop_pl_nxt = drop_pl;
    pop         = 1'b0;
    out_wr      = '0;
    pkt_inc     = 1'b0;
    drop_inc    = 1'b0;
    err_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          drop_pl_nxt = 1'b0;
          if (head_ctrl == IOQ_STAGE_NUM) begin
            bitmap_nxt = hdr_bitmap;
          end else begin
            bitmap_nxt = DEFAULT_PORTS;
            err_inc    = 1'b1;
          end
          state_nxt = (bitmap_nxt == '0) ? DROP : HDRS;
        end
      end
      HDRS: begin
        if (send) begin
          out_wr = bitmap;
          pop    = 1'b1;
          if (head_ctrl == '0) state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (send) begin
          out_wr = bitmap;
          pop    = 1'b1;
          if (head_ctrl != '0) begin
            pkt_inc   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!drop_pl) begin
            if (head_ctrl == '0) drop_pl_nxt = 1'b1;
          end else if (head_ctrl != '0) begin
            drop_inc  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count     <= '0;
      drop_count    <= '0;
      hdr_err_count <= '0;
    end else begin
      if (pkt_inc)  pkt_count     <= pkt_count + 32'd1;
      if (drop_inc) drop_count    <= drop_count + 32'd1;
      if (err_inc)  hdr_err_count <= hdr_err_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_oq_dst_dispatch.sv
// Randomized self-checking bench for oq_dst_dispatch against a packet-level model.
module tb_oq_dst_dispatch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic [7:0]  out_wr;
  logic [7:0]  out_rdy;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;
  logic [31:0] hdr_err_count;

  oq_dst_dispatch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .in_wr         (in_wr),
    .in_rdy        (in_rdy),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .out_wr        (out_wr),
    .out_rdy       (out_rdy),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .hdr_err_count (hdr_err_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic [7:0] c; } word_t;
  typedef struct { logic [63:0] d; logic [7:0] c; logic [7:0] m; } exp_t;

  word_t src_q[$];
  exp_t  exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int exp_pkt = 0;
  int exp_drop = 0;
  int exp_err = 0;
  int words_out = 0;
  logic [7:0] rdy_base = 8'hFF;
  bit   rdy_rand = 1'b0;
  int   stall_left = 0;
  int   stall_at = 0;
  logic [7:0] stall_mask = 8'h00;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Model: the destination set is the header bitmap when the first word is an
  // IO-queue header, otherwise 0x55; an empty set means the packet is dropped.
  task automatic add_pkt(input logic [7:0] c0, input logic [7:0] bm, input int nhdr, input int npay);
    word_t pk[$];
    word_t w;
    logic [7:0] eff;
    eff = (c0 == 8'hFF) ? bm : 8'h55;
    w.d = {$urandom, $urandom};
    w.d[55:48] = bm;
    w.c = c0;
    pk.push_back(w);
    repeat (nhdr) begin
      w.d = {$urandom, $urandom};
      w.c = 8'($urandom_range(1, 255));
      pk.push_back(w);
    end
    repeat (npay) begin
      w.d = {$urandom, $urandom};
      w.c = 8'h00;
      pk.push_back(w);
    end
    w.d = {$urandom, $urandom};
    w.c = 8'h01;
    pk.push_back(w);
    foreach (pk[i]) begin
      src_q.push_back(pk[i]);
      if (eff != 8'h00) exp_q.push_back('{d: pk[i].d, c: pk[i].c, m: eff});
    end
    if (eff == 8'h00) exp_drop++;
    else exp_pkt++;
    if (c0 != 8'hFF) exp_err++;
  endtask

  task automatic cycle();
    exp_t  e;
    word_t w;
    @(negedge clk);
    out_rdy = rdy_rand ? 8'($urandom | $urandom | $urandom) : rdy_base;
    if (stall_left > 0) out_rdy = out_rdy & ~stall_mask;
    #1;
    if (stall_left > 0) begin
      chk("stall_no_wr", 64'(out_wr), 64'd0);
      stall_left--;
    end
    if (out_wr != 8'h00) begin
      chk("wr_only_ready", 64'(out_wr & ~out_rdy), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 64'(out_wr), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_wr", 64'(out_wr), 64'(e.m));
        chk("out_data", out_data, e.d);
        chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
      end
      words_out++;
      if (stall_at > 0 && words_out == stall_at) begin
        stall_left = 5;
        stall_at = 0;
      end
    end
    if (src_q.size() > 0 && in_rdy) begin
      w = src_q.pop_front();
      in_wr = 1'b1;
      in_data = w.d;
      in_ctrl = w.c;
    end else begin
      in_wr = 1'b0;
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkt));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
    chk({tag, "_hdr_err_count"}, 64'(hdr_err_count), 64'(exp_err));
  endtask

  task automatic run(input int budget, input string tag);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_words_left"}, 64'(src_q.size() + exp_q.size()), 64'd0);
    repeat (20) cycle();
    check_counters(tag);
  endtask

  initial begin
    int w0;
    int n;
    reset_n = 1'b0;
    in_wr   = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = 8'hFF;
    #3;
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    check_counters("rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Unicast to queue 2.
    rdy_base = 8'hFF;
    add_pkt(8'hFF, 8'h04, 1, 6);
    run(60, "unicast");

    // Multicast to queues 0 and 2, queue 2 stalls for 5 cycles mid-payload.
    stall_mask = 8'h04;
    stall_at = words_out + 4;
    add_pkt(8'hFF, 8'h05, 1, 6);
    run(80, "mcast_stall");
    chk("stall_happened", 64'(stall_at), 64'd0);

    // Only the selected queue is ready; the packet must not stall.
    rdy_base = 8'h01;
    add_pkt(8'hFF, 8'h01, 1, 6);
    run(40, "unrelated_stall");

    // Empty bitmap, immediately followed by a unicast to queue 1.
    rdy_base = 8'hFF;
    add_pkt(8'hFF, 8'h00, 1, 7);
    add_pkt(8'hFF, 8'h02, 1, 6);
    run(80, "drop_then_fwd");

    // First word is not an IO-queue header: default queues.
    add_pkt(8'h10, 8'h3C, 1, 4);
    run(60, "hdr_err");

    // Random traffic with random per-queue ready.
    rdy_rand = 1'b1;
    repeat (25) begin
      logic [7:0] c0;
      logic [7:0] bm;
      c0 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 254)) : 8'hFF;
      bm = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      add_pkt(c0, bm, $urandom_range(0, 2), $urandom_range(1, 8));
    end
    run(6000, "random");
    rdy_rand = 1'b0;

    // Reset in the middle of a packet.
    rdy_base = 8'hFF;
    add_pkt(8'hFF, 8'h06, 1, 6);
    w0 = words_out;
    n = 0;
    while (words_out - w0 < 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("pre_reset_words", 64'(words_out - w0), 64'd3);
    #2;
    reset_n = 1'b0;
    in_wr = 1'b0;
    #1;
    chk("reset_out_wr", 64'(out_wr), 64'd0);
    src_q.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    exp_err = 0;
    check_counters("reset_mid");
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hold_out_wr", 64'(out_wr), 64'd0);
    reset_n = 1'b1;
    add_pkt(8'hFF, 8'h0A, 1, 3);
    run(60, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
